// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_pkg
//  Description : Shared definitions for the instruction encoder/decoder pair:
//                field widths, instruction code table, RV32 opcode and
//                funct3/funct7 constants, and the encoder FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_encoder_pkg;

    // Field widths shared with the decoder
    localparam int ISIZE = 32;   // encoded instruction width
    localparam int ASIZE = 5;    // register address width
    localparam int DSIZE = 32;   // immediate width

    // Instruction code table (common to encoder and decoder)
    localparam logic [3:0] CODE_ADD  = 4'd0;
    localparam logic [3:0] CODE_MUL  = 4'd1;
    localparam logic [3:0] CODE_ADDI = 4'd2;
    localparam logic [3:0] CODE_LW   = 4'd3;
    localparam logic [3:0] CODE_SW   = 4'd4;
    localparam logic [3:0] CODE_JAL  = 4'd5;
    localparam logic [3:0] CODE_JR   = 4'd6;
    localparam logic [3:0] CODE_BNE  = 4'd7;

    // RV32 major opcodes
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // funct3 / funct7
    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_JALR   = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;
    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [6:0] F7_MUL    = 7'b0000001;

    // addi x0, x0, 0
    localparam logic [ISIZE-1:0] NOP_WORD = 32'h0000_0013;

    // Encoder load-sequencer states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage : instr_encoder_pkg
`default_nettype wire

// File: rtl/instr_pack.sv
`default_nettype none
// ============================================================================
//  Module      : instr_pack
//  Description : Combinational RV32 packer. Turns one set of instruction
//                fields into a 32-bit instruction word and flags unknown
//                codes (NOP emitted). With IMM_RANGE_CHECK_EN defined it also
//                flags immediates that do not fit their field; the truncated
//                encoding is produced either way.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [3:0]       code_i,
    input  logic [ASIZE-1:0] rs1_i,
    input  logic [ASIZE-1:0] rs2_i,
    input  logic [ASIZE-1:0] rd_i,
    input  logic [DSIZE-1:0] imm_i,
    output logic [ISIZE-1:0] word_o,
    output logic             err_o
);

    logic w_unknown;
    logic w_range_bad;

    // Field packing per instruction format
    always_comb begin
        word_o    = NOP_WORD;
        w_unknown = 1'b0;
        case (code_i)
            CODE_ADD:  word_o = {F7_ADD, rs2_i, rs1_i, F3_ADD, rd_i, OP_REG};
            CODE_MUL:  word_o = {F7_MUL, rs2_i, rs1_i, F3_ADD, rd_i, OP_REG};
            CODE_ADDI: word_o = {imm_i[11:0], rs1_i, F3_ADD, rd_i, OP_IMM};
            CODE_LW:   word_o = {imm_i[11:0], rs1_i, F3_WORD, rd_i, OP_LOAD};
            CODE_SW:   word_o = {imm_i[11:5], rs2_i, rs1_i, F3_WORD,
                                 imm_i[4:0], OP_STORE};
            CODE_JAL:  word_o = {imm_i[20], imm_i[10:1], imm_i[11],
                                 imm_i[19:12], rd_i, OP_JAL};
            // JR is jalr x0, 0(rs1): rd and imm inputs are ignored
            CODE_JR:   word_o = {12'd0, rs1_i, F3_JALR, 5'd0, OP_JALR};
            CODE_BNE:  word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_BNE,
                                 imm_i[4:1], imm_i[11], OP_BRANCH};
            default:   w_unknown = 1'b1;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // An immediate fits when every bit above the field's sign bit equals it
    logic w_fit_i12;
    logic w_fit_b13;
    logic w_fit_j21;

    assign w_fit_i12 = (imm_i[DSIZE-1:11] == '0) || (imm_i[DSIZE-1:11] == '1);
    assign w_fit_b13 = ((imm_i[DSIZE-1:12] == '0) || (imm_i[DSIZE-1:12] == '1))
                       && !imm_i[0];
    assign w_fit_j21 = ((imm_i[DSIZE-1:20] == '0) || (imm_i[DSIZE-1:20] == '1))
                       && !imm_i[0];

    // Select the range rule matching the instruction format
    always_comb begin
        w_range_bad = 1'b0;
        case (code_i)
            CODE_ADDI, CODE_LW, CODE_SW: w_range_bad = !w_fit_i12;
            CODE_BNE:                    w_range_bad = !w_fit_b13;
            CODE_JAL:                    w_range_bad = !w_fit_j21;
            default:                     w_range_bad = 1'b0;
        endcase
    end
`else
    // Upper immediate bits only matter for range checking
    logic w_unused_imm_hi;
    assign w_unused_imm_hi = ^imm_i[DSIZE-1:21];
    assign w_range_bad     = 1'b0;
`endif

    assign err_o = w_unknown | w_range_bad;

endmodule : instr_pack
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Program loader. Accepts instruction fields over a
//                valid/ready handshake, encodes them to RV32 words and writes
//                them to instruction memory at consecutive word addresses
//                from BASE_ADDR. Sticky err on unknown codes and on
//                overflowing MEM_DEPTH words. Optional macro
//                IMM_RANGE_CHECK_EN adds immediate range checking.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int          MEM_DEPTH = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [3:0]              instr_code,
    input  logic [ASIZE-1:0]        rs1,
    input  logic [ASIZE-1:0]        rs2,
    input  logic [ASIZE-1:0]        rd,
    input  logic signed [DSIZE-1:0] imm,
    output logic                    mem_we,
    input  logic                    mem_ready,
    output logic [31:0]             mem_addr,
    output logic [ISIZE-1:0]        mem_wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [31:0]             word_count
);

    localparam logic [31:0] C_DEPTH = 32'(MEM_DEPTH);

    state_t           state_q, state_d;
    logic [3:0]       code_q;
    logic [ASIZE-1:0] rs1_q, rs2_q, rd_q;
    logic [DSIZE-1:0] imm_q;
    logic             last_q;
    logic [31:0]      addr_q;
    logic [31:0]      count_q;
    logic             err_q;

    logic             w_hs;
    logic             w_full;
    logic             w_wr_done;
    logic [ISIZE-1:0] w_word;
    logic             w_pack_err;

    assign w_hs      = (state_q == S_ACCEPT) && in_valid;
    // All MEM_DEPTH words already written: further handshakes must not write
    assign w_full    = (count_q == C_DEPTH);
    assign w_wr_done = (state_q == S_WRITE) && mem_ready;

    instr_pack u_pack (
        .code_i (code_q),
        .rs1_i  (rs1_q),
        .rs2_i  (rs2_q),
        .rd_i   (rd_q),
        .imm_i  (imm_q),
        .word_o (w_word),
        .err_o  (w_pack_err)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start)     state_d = S_ACCEPT;
            S_ACCEPT: if (in_valid)  state_d = w_full ? S_DONE : S_WRITE;
            S_WRITE:  if (mem_ready) state_d = last_q ? S_DONE : S_ACCEPT;
            S_DONE:                  state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // Holding register, address/count tracking and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            last_q  <= 1'b0;
            addr_q  <= BASE_ADDR;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if ((state_q == S_IDLE) && start) begin
                addr_q  <= BASE_ADDR;
                count_q <= '0;
                err_q   <= 1'b0;
            end
            if (w_hs) begin
                if (w_full) begin
                    err_q <= 1'b1;
                end else begin
                    code_q <= instr_code;
                    rs1_q  <= rs1;
                    rs2_q  <= rs2;
                    rd_q   <= rd;
                    imm_q  <= imm;
                    last_q <= in_last;
                end
            end
            if (w_wr_done) begin
                addr_q  <= addr_q + 32'd4;
                count_q <= count_q + 32'd1;
                if (w_pack_err) err_q <= 1'b1;
            end
        end
    end

    // Outputs decoded from state; write data forced to zero outside WRITE
    always_comb begin
        in_ready   = (state_q == S_ACCEPT);
        mem_we     = (state_q == S_WRITE);
        busy       = (state_q == S_ACCEPT) || (state_q == S_WRITE);
        done       = (state_q == S_DONE);
        mem_wdata  = (state_q == S_WRITE) ? w_word : '0;
        mem_addr   = addr_q;
        err        = err_q;
        word_count = count_q;
    end

endmodule : instr_encoder
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_encoder
//  Description : Self-checking bench for instr_encoder. A default-depth
//                instance runs table-driven programs; a MEM_DEPTH=4 instance
//                sharing the same stimulus covers memory overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;
    import instr_encoder_pkg::*;

`ifdef IMM_RANGE_CHECK_EN
    localparam logic EXP_RANGE_ERR = 1'b1;
`else
    localparam logic EXP_RANGE_ERR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_last;
    logic [3:0]        instr_code;
    logic [ASIZE-1:0]  rs1, rs2, rd;
    logic signed [DSIZE-1:0] imm;
    logic              mem_ready;

    logic              in_ready, mem_we, busy, done, err;
    logic [31:0]       mem_addr, word_count;
    logic [ISIZE-1:0]  mem_wdata;

    logic              sm_in_ready, sm_mem_we, sm_busy, sm_done, sm_err;
    logic [31:0]       sm_mem_addr, sm_word_count;
    logic [ISIZE-1:0]  sm_mem_wdata;

    int n_vec = 0;
    int n_mis = 0;
    int wr_cnt = 0;
    int sm_wr_cnt = 0;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .instr_code(instr_code), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .mem_we(mem_we), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .word_count(word_count)
    );

    instr_encoder #(.MEM_DEPTH(4), .BASE_ADDR(32'h0)) dut_small (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(sm_in_ready), .in_last(in_last),
        .instr_code(instr_code), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .mem_we(sm_mem_we), .mem_ready(mem_ready),
        .mem_addr(sm_mem_addr), .mem_wdata(sm_mem_wdata),
        .busy(sm_busy), .done(sm_done), .err(sm_err), .word_count(sm_word_count)
    );

    // Count completed memory writes on each instance
    always @(posedge clk) begin
        if (mem_we && mem_ready)       wr_cnt    <= wr_cnt + 1;
        if (sm_mem_we && mem_ready)    sm_wr_cnt <= sm_wr_cnt + 1;
    end

    typedef struct {
        logic [3:0]  code;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        last;
        logic        first;
        int          stall;
        logic [31:0] exp_addr;
        logic [31:0] exp_word;
        logic [31:0] exp_count;
        logic        exp_err;
    } vec_t;

    vec_t tbl [10];

    function automatic vec_t mk(input logic [3:0] code, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [4:0] rdd,
                                input logic [31:0] im, input logic last,
                                input logic first, input int stall,
                                input logic [31:0] ea, input logic [31:0] ew,
                                input logic [31:0] ec, input logic ee);
        vec_t v;
        v.code = code; v.rs1 = r1; v.rs2 = r2; v.rd = rdd; v.imm = im;
        v.last = last; v.first = first; v.stall = stall;
        v.exp_addr = ea; v.exp_word = ew; v.exp_count = ec; v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("start_busy", busy, 1'b1);
        chk1("start_in_ready", in_ready, 1'b1);
        chk1("start_err_clear", err, 1'b0);
        chk("start_count", word_count, 32'd0);
        chk("start_addr", mem_addr, 32'd0);
    endtask

    task automatic handshake(input vec_t v);
        int n;
        in_valid   = 1'b1;
        instr_code = v.code;
        rs1 = v.rs1; rs2 = v.rs2; rd = v.rd;
        imm = v.imm;
        in_last = v.last;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk1("hs_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic complete_write(input vec_t v, input int wr_before);
        chk1("wr_we", mem_we, 1'b1);
        chk("wr_addr", mem_addr, v.exp_addr);
        chk("wr_data", mem_wdata, v.exp_word);
        chk1("wr_in_ready", in_ready, 1'b0);
        for (int s = 0; s < v.stall; s++) begin
            tick();
            chk1("stall_we", mem_we, 1'b1);
            chk("stall_addr", mem_addr, v.exp_addr);
            chk("stall_data", mem_wdata, v.exp_word);
            chk1("stall_in_ready", in_ready, 1'b0);
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("wr_once", 32'(wr_cnt), 32'(wr_before + 1));
        chk("wr_count", word_count, v.exp_count);
        chk1("wr_err", err, v.exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int wb;
        tbl[0] = mk(CODE_ADD,  5'd1, 5'd2, 5'd3, 32'd0,        1'b0, 1'b1, 5, 32'h00, 32'h002081B3, 32'd1, 1'b0);
        tbl[1] = mk(CODE_MUL,  5'd1, 5'd2, 5'd3, 32'd0,        1'b0, 1'b0, 0, 32'h04, 32'h022081B3, 32'd2, 1'b0);
        tbl[2] = mk(CODE_ADDI, 5'd0, 5'd0, 5'd5, 32'hFFFFFFFF, 1'b0, 1'b0, 0, 32'h08, 32'hFFF00293, 32'd3, 1'b0);
        tbl[3] = mk(CODE_LW,   5'd1, 5'd0, 5'd6, 32'd8,        1'b0, 1'b0, 0, 32'h0C, 32'h0080A303, 32'd4, 1'b0);
        tbl[4] = mk(CODE_SW,   5'd1, 5'd2, 5'd0, 32'd12,       1'b1, 1'b0, 0, 32'h10, 32'h0020A623, 32'd5, 1'b0);
        tbl[5] = mk(CODE_JAL,  5'd0, 5'd0, 5'd1, 32'hFFFFFFFC, 1'b0, 1'b1, 0, 32'h00, 32'hFFDFF0EF, 32'd1, 1'b0);
        tbl[6] = mk(CODE_JR,   5'd1, 5'd0, 5'd7, 32'd0,        1'b0, 1'b0, 0, 32'h04, 32'h00008067, 32'd2, 1'b0);
        tbl[7] = mk(CODE_BNE,  5'd5, 5'd6, 5'd0, 32'hFFFFFFF8, 1'b0, 1'b0, 0, 32'h08, 32'hFE629CE3, 32'd3, 1'b0);
        tbl[8] = mk(CODE_ADDI, 5'd0, 5'd0, 5'd1, 32'd2048,     1'b0, 1'b0, 0, 32'h0C, 32'h80000093, 32'd4, EXP_RANGE_ERR);
        tbl[9] = mk(4'hF,      5'd0, 5'd0, 5'd3, 32'd0,        1'b1, 1'b0, 0, 32'h10, 32'h00000013, 32'd5, 1'b1);

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        instr_code = '0; rs1 = '0; rs2 = '0; rd = '0; imm = '0; mem_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk("rst_count", word_count, 32'd0);

        // Two five-instruction programs from the table
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].first) do_start();
            wb = wr_cnt;
            handshake(tbl[i]);
            if (i == 4) begin
                // Depth-4 instance: fifth handshake ends the load without writing
                chk1("ovf_done", sm_done, 1'b1);
                chk1("ovf_err", sm_err, 1'b1);
                chk1("ovf_we", sm_mem_we, 1'b0);
                chk("ovf_count", sm_word_count, 32'd4);
                chk("ovf_writes", 32'(sm_wr_cnt), 32'd4);
            end
            complete_write(tbl[i], wb);
            if (tbl[i].last) begin
                chk1("done_pulse", done, 1'b1);
                chk1("done_busy", busy, 1'b0);
                tick();
                chk1("done_clear", done, 1'b0);
                chk1("idle_busy", busy, 1'b0);
            end
        end

        // Sticky err holds in IDLE and clears on the next start
        tick();
        chk1("err_sticky", err, 1'b1);
        do_start();

        // Reset during WRITE abandons the write
        wb = wr_cnt;
        handshake(tbl[0]);
        chk1("pre_rst_we", mem_we, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("rstw_we", mem_we, 1'b0);
        chk1("rstw_busy", busy, 1'b0);
        chk1("rstw_in_ready", in_ready, 1'b0);
        chk("rstw_count", word_count, 32'd0);
        chk("rstw_addr", mem_addr, 32'd0);
        chk("rstw_writes", 32'(wr_cnt), 32'(wb));

        // start together with in_valid in IDLE accepts nothing
        instr_code = CODE_ADD; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3;
        start = 1'b1; in_valid = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b0;
        chk1("sv_in_ready", in_ready, 1'b1);
        chk1("sv_we", mem_we, 1'b0);
        tick(); tick();
        chk1("sv_we_later", mem_we, 1'b0);
        chk("sv_count", word_count, 32'd0);
        chk1("sv_busy", busy, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule : tb_instr_encoder
`default_nettype wire
